// File: rtl/inv_cipher_iter_pkg.sv
// AES helpers shared by the inverse cipher: GF(2^8) arithmetic, S-boxes,
// Rcon, and the whole-state inverse transforms. State byte i lives at
// bits [127-8*i -: 8]; byte index = row + 4*column (column-major).
package inv_cipher_iter_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_INIT, ST_ROUND} fsm_state_t;

   localparam int N_ROWS = 4;
   localparam int N_COLS = 4;

   function automatic int bidx(input int r, input int c);
      return r + N_ROWS * c;
   endfunction

   function automatic logic [7:0] get_byte(input logic [127:0] s, input int i);
      return s[127-8*i -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

   function automatic logic [7:0] gmul9(input logic [7:0] x);  return gmul(x, 8'h09); endfunction
   function automatic logic [7:0] gmul11(input logic [7:0] x); return gmul(x, 8'h0b); endfunction
   function automatic logic [7:0] gmul13(input logic [7:0] x); return gmul(x, 8'h0d); endfunction
   function automatic logic [7:0] gmul14(input logic [7:0] x); return gmul(x, 8'h0e); endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   // Multiplicative inverse as x^254 (0 maps to 0), avoiding a 256-entry table.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = x;
      for (int i = 1; i < 8; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] v;
      v = gf_inv(b);
      return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // Rcon[j] for j = 1..10: 01,02,...,80,1b,36.
   function automatic logic [7:0] rcon(input logic [3:0] j);
      logic [7:0] r;
      r = 8'h01;
      for (int k = 1; k < 11; k++) begin
         if (k < int'(j)) r = xtime(r);
      end
      return r;
   endfunction

   // Row r rotates right by r columns.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int r = 0; r < N_ROWS; r++)
         for (int c = 0; c < N_COLS; c++)
            o[127-8*bidx(r, c) -: 8] = get_byte(s, bidx(r, (c - r + 4) % 4));
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(get_byte(s, i));
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0] a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < N_COLS; c++) begin
         a0 = get_byte(s, bidx(0, c));
         a1 = get_byte(s, bidx(1, c));
         a2 = get_byte(s, bidx(2, c));
         a3 = get_byte(s, bidx(3, c));
         o[127-8*bidx(0, c) -: 8] = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
         o[127-8*bidx(1, c) -: 8] = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
         o[127-8*bidx(2, c) -: 8] = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
         o[127-8*bidx(3, c) -: 8] = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);
      end
      return o;
   endfunction

endpackage

// File: rtl/inv_cipher_iter_inv_round.sv
// One combinational inverse AES round. The final round (is_last) skips
// InvMixColumns; all other rounds apply it after AddRoundKey.
module inv_round
   import inv_cipher_iter_pkg::*;
(
   input  logic [127:0] blk,
   input  logic [127:0] round_key,
   input  logic         is_last,
   output logic [127:0] result
);

   logic [127:0] keyed;

   // InvShiftRows -> InvSubBytes -> AddRoundKey -> optional InvMixColumns.
   always_comb begin
      keyed  = inv_sub_bytes(inv_shift_rows(blk)) ^ round_key;
      result = is_last ? keyed : inv_mix_columns(keyed);
   end

endmodule

// File: rtl/inv_cipher_iter.sv
// Iterative AES inverse cipher. Accepts a block and key, expands the key
// schedule one word per cycle, applies the last round key, then runs one
// inverse round per cycle down to round key 0.
// Handshake: a request is taken on a rising edge with i_start=1 and
// o_busy=0; o_busy stays high until the completion edge, after which
// o_valid pulses for exactly one cycle with the result in o_data.
module inv_cipher_iter
   import inv_cipher_iter_pkg::*;
#(
   parameter int nk = 8,
   parameter int nr = 14
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   input  logic [32*nk-1:0] i_key,
   input  logic [127:0]    i_data,
   output logic [127:0]    o_data,
   output logic            o_valid,
   output logic            o_busy
);

   localparam int NW = 4 * (nr + 1);
   localparam int WW = $clog2(NW + 1);
   localparam int RW = $clog2(nr + 1);

   fsm_state_t     state_q, state_d;
   logic [WW-1:0]  wcnt;
   logic [RW-1:0]  rcnt;
   logic [127:0]   blk;
   logic [31:0]    w [NW];

   logic           accept, expand_en, init_en, round_en, done;
   logic [WW-1:0]  idx_prev, idx_back, wmod, rk_base;
   logic [RW-1:0]  rk_round;
   logic [31:0]    prev_word, temp, new_word;
   logic [127:0]   round_key, round_out;
   logic           is_last;

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (i_start) state_d = ST_EXPAND;
         ST_EXPAND: if (wcnt == WW'(NW - 1)) state_d = ST_INIT;
         ST_INIT:   state_d = ST_ROUND;
         ST_ROUND:  if (rcnt == '0) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Per-state control strobes.
   always_comb begin
      accept    = 1'b0;
      expand_en = 1'b0;
      init_en   = 1'b0;
      round_en  = 1'b0;
      done      = 1'b0;
      o_busy    = (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE:   accept    = i_start;
         ST_EXPAND: expand_en = 1'b1;
         ST_INIT:   init_en   = 1'b1;
         ST_ROUND: begin
            round_en = 1'b1;
            done     = (rcnt == '0);
         end
         default: ;
      endcase
   end

   // Key-schedule step: temp is w[i-1], transformed depending on i mod nk.
   always_comb begin
      idx_prev  = wcnt - WW'(1);
      idx_back  = wcnt - WW'(nk);
      wmod      = wcnt % WW'(nk);
      prev_word = w[idx_prev];
      if (wmod == '0)
         temp = sub_word(rot_word(prev_word)) ^ {rcon(4'(wcnt / WW'(nk))), 24'h0};
      else if (nk > 6 && wmod == WW'(4))
         temp = sub_word(prev_word);
      else
         temp = prev_word;
      new_word = w[idx_back] ^ temp;
   end

   // Round-key fetch: key nr during INIT, otherwise the current round counter.
   always_comb begin
      rk_round  = (state_q == ST_INIT) ? RW'(nr) : rcnt;
      rk_base   = WW'({rk_round, 2'b00});
      round_key = {w[rk_base], w[rk_base + WW'(1)], w[rk_base + WW'(2)], w[rk_base + WW'(3)]};
      is_last   = (rcnt == '0);
   end

   inv_round u_inv_round (
      .blk       (blk),
      .round_key (round_key),
      .is_last   (is_last),
      .result    (round_out)
   );

   // Round-key store: cipher key on acceptance, one expanded word per EXPAND edge.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         if (accept) begin
            for (int j = 0; j < nk; j++) w[j] <= i_key[32*(nk-j)-1 -: 32];
         end else if (expand_en) begin
            w[wcnt] <= new_word;
         end
      end
   end

   // Datapath state, counters and result register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         blk     <= '0;
         wcnt    <= '0;
         rcnt    <= '0;
         o_data  <= '0;
         o_valid <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         if (accept) begin
            blk  <= i_data;
            wcnt <= WW'(nk);
         end
         if (expand_en) wcnt <= wcnt + WW'(1);
         if (init_en) begin
            blk  <= blk ^ round_key;
            rcnt <= RW'(nr - 1);
         end
         if (round_en) begin
            blk <= round_out;
            if (done) begin
               o_data  <= round_out;
               o_valid <= 1'b1;
            end else begin
               rcnt <= rcnt - RW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_inv_cipher_iter.sv
// Bench for inv_cipher_iter: AES-256, AES-192 and AES-128 instances driven
// from directed FIPS-197 vectors. Expected results and completion cycles
// go into per-instance queues; a monitor pops them when o_valid appears.
module tb_inv_cipher_iter;

   localparam int L8 = 67;
   localparam int L6 = 59;
   localparam int L4 = 51;

   localparam logic [255:0] KEY8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [191:0] KEY6 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [127:0] KEY4 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT8  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] CT6  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT4  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;

   // Clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic         start8, start6, start4;
   logic [255:0] key8;
   logic [191:0] key6;
   logic [127:0] key4;
   logic [127:0] data8, data6, data4;
   logic [127:0] q8, q6, q4;
   logic         v8, v6, v4, b8, b6, b4;

   inv_cipher_iter #(.nk(8), .nr(14)) dut8 (
      .i_clk(clk), .i_rst(rst), .i_start(start8), .i_key(key8), .i_data(data8),
      .o_data(q8), .o_valid(v8), .o_busy(b8));
   inv_cipher_iter #(.nk(6), .nr(12)) dut6 (
      .i_clk(clk), .i_rst(rst), .i_start(start6), .i_key(key6), .i_data(data6),
      .o_data(q6), .o_valid(v6), .o_busy(b6));
   inv_cipher_iter #(.nk(4), .nr(10)) dut4 (
      .i_clk(clk), .i_rst(rst), .i_start(start4), .i_key(key4), .i_data(data4),
      .o_data(q4), .o_valid(v4), .o_busy(b4));

   // Scoreboard: {expected completion cycle, expected plaintext}
   logic [159:0] exp_q8[$];
   logic [159:0] exp_q6[$];
   logic [159:0] exp_q4[$];
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic mon_one(input int id, input logic v, input logic b, input logic [127:0] d,
                          input logic pv);
      logic [159:0] e;
      bit have;
      have = 1'b0;
      e    = '0;
      if (v) begin
         check($sformatf("dut%0d_valid_single_cycle", id), 128'(pv), 128'(0));
         case (id)
            8: if (exp_q8.size() > 0) begin have = 1'b1; e = exp_q8.pop_front(); end
            6: if (exp_q6.size() > 0) begin have = 1'b1; e = exp_q6.pop_front(); end
            default: if (exp_q4.size() > 0) begin have = 1'b1; e = exp_q4.pop_front(); end
         endcase
         if (!have) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dut%0d_unexpected_valid: got o_valid=1 at cycle %0d, required no pending result", id, cyc);
         end else begin
            check($sformatf("dut%0d_data", id), d, e[127:0]);
            check($sformatf("dut%0d_cycle", id), 128'(cyc), 128'(e[159:128]));
            check($sformatf("dut%0d_busy_at_valid", id), 128'(b), 128'(0));
         end
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   task automatic run_monitor();
      logic pv8, pv6, pv4;
      pv8 = 1'b0; pv6 = 1'b0; pv4 = 1'b0;
      forever begin
         @(negedge clk);
         mon_one(8, v8, b8, q8, pv8);
         mon_one(6, v6, b6, q6, pv6);
         mon_one(4, v4, b4, q4, pv4);
         pv8 = v8; pv6 = v6; pv4 = v4;
      end
   endtask

   // Driver: pulse start on dut8 for one edge; optionally predict the result.
   task automatic go8(input logic [127:0] d, input bit predict);
      @(posedge clk); #1;
      start8 = 1'b1;
      data8  = d;
      if (predict) exp_q8.push_back({32'(cyc + 1 + L8), PT});
      @(posedge clk); #1;
      start8 = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((exp_q8.size() + exp_q6.size() + exp_q4.size()) > 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check("drain_pending", 128'(exp_q8.size() + exp_q6.size() + exp_q4.size()), 128'(0));
   endtask

   initial begin
      int busy_low;
      int n;
      rst = 1'b1;
      start8 = 1'b0; start6 = 1'b0; start4 = 1'b0;
      key8 = KEY8; key6 = KEY6; key4 = KEY4;
      data8 = '0; data6 = '0; data4 = '0;
      fork
         run_monitor();
      join_none

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_data8", q8, 128'(0));
      check("rst_valid8", 128'(v8), 128'(0));
      check("rst_busy8", 128'(b8), 128'(0));
      check("rst_data6", q6, 128'(0));
      check("rst_busy4", 128'(b4), 128'(0));
      rst = 1'b0;

      // All three key sizes in parallel; dut8 busy must hold until completion
      @(posedge clk); #1;
      start8 = 1'b1; data8 = CT8;
      start6 = 1'b1; data6 = CT6;
      start4 = 1'b1; data4 = CT4;
      exp_q8.push_back({32'(cyc + 1 + L8), PT});
      exp_q6.push_back({32'(cyc + 1 + L6), PT});
      exp_q4.push_back({32'(cyc + 1 + L4), PT});
      @(posedge clk); #1;
      start8 = 1'b0; start6 = 1'b0; start4 = 1'b0;
      busy_low = 0;
      for (int i = 0; i < L8 - 1; i++) begin
         @(negedge clk);
         if (b8 !== 1'b1) busy_low++;
      end
      check("dut8_busy_hold", 128'(busy_low), 128'(0));
      drain(150);

      // Start while busy is ignored; start in the o_valid cycle is accepted
      go8(CT8, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      start8 = 1'b1;
      data8  = 128'hffeeddccbbaa99887766554433221100;
      key8   = ~KEY8;
      @(posedge clk); #1;
      start8 = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (v8 !== 1'b1 && n < 100);
      check("dut8_first_valid_seen", 128'(v8), 128'(1));
      key8   = KEY8;
      data8  = CT8;
      start8 = 1'b1;
      exp_q8.push_back({32'(cyc + 1 + L8), PT});
      @(posedge clk); #1;
      start8 = 1'b0;
      drain(150);

      // Reset and start on the same edge: reset wins
      @(posedge clk); #1;
      rst = 1'b1; start8 = 1'b1; data8 = CT8;
      @(posedge clk); #1;
      rst = 1'b0; start8 = 1'b0;
      check("rst_wins_busy8", 128'(b8), 128'(0));

      // Reset 20 cycles into an operation aborts it with no result
      go8(CT8, 1'b0);
      repeat (18) @(posedge clk);
      #1;
      check("pre_abort_busy8", 128'(b8), 128'(1));
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy8", 128'(b8), 128'(0));
      check("abort_valid8", 128'(v8), 128'(0));
      check("abort_data8", q8, 128'(0));
      repeat (80) @(negedge clk);

      // Restart after reset with the first vector
      go8(CT8, 1'b1);
      drain(150);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
